// File: rtl/vmsu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vmsu_arb_pkg
// Description : Shared defaults and types for the shared-multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vmsu_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ID_W       = 2;
  localparam int DEF_MUL_LAT    = 2;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int PROD_W         = 16;
  localparam int OPND_W         = 8;

  // Response entry at default widths: requester ID above the product.
  typedef struct packed {
    logic [DEF_ID_W-1:0] id;
    logic [PROD_W-1:0]   p;
  } rsp_entry_t;

endpackage
`default_nettype wire

// File: rtl/vmsu_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vmsu_rsp_fifo
// Description : Synchronous first-word fall-through FIFO with count output.
// Revision    : 1.0 - initial release
// ============================================================================
module vmsu_rsp_fifo #(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_rd,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_pop;
  logic              w_full;

  assign o_valid = (r_count != '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign w_pop   = i_rd & o_valid;
  assign w_full  = (r_count == (AW+1)'(DEPTH));

  // Storage, pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue credit upstream must make a write into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(i_wr && w_full && !w_pop));

endmodule
`default_nettype wire

// File: rtl/vmsu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vmsu_mul_arbiter
// Description : Round-robin, credit-controlled sharing of one 8x8 multiplier
//               among NUM_REQ requesters, with an ID tag pipeline and an
//               in-order response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module vmsu_mul_arbiter
  import vmsu_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ID_W       = DEF_ID_W,
  parameter int MUL_LAT    = DEF_MUL_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [OPND_W*NUM_REQ-1:0]  i_req_a,
  input  logic [OPND_W*NUM_REQ-1:0]  i_req_b,
  input  logic [NUM_REQ-1:0]         i_req_signed,
  output logic [OPND_W-1:0]          o_mul_a,
  output logic [OPND_W-1:0]          o_mul_b,
  output logic                       o_mul_control,
  input  logic [PROD_W-1:0]          i_mul_p,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [ID_W-1:0]            o_rsp_id,
  output logic [PROD_W-1:0]          o_rsp_p,
  output logic                       o_busy
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + MUL_LAT + 1) + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [PROD_W-1:0] p;
  } entry_t;

  logic [OPND_W-1:0]            r_mul_a;
  logic [OPND_W-1:0]            r_mul_b;
  logic                         r_mul_control;
  logic [ID_W-1:0]              r_rr_ptr;
  logic [MUL_LAT:0]             r_tag_vld;
  logic [MUL_LAT:0][ID_W-1:0]   r_tag_id;

  logic                         w_grant_vld;
  int                           w_grant_idx;
  logic [ID_W-1:0]              w_grant_id;
  logic                         w_accept;
  logic [CNT_W-1:0]             w_inflight;
  logic [FCNT_W-1:0]            w_fifo_count;
  logic                         w_issue_ok;
  entry_t                       w_wentry;
  entry_t                       w_head;

  // Count valid tag stages: operations issued but not yet written into the FIFO.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k <= MUL_LAT; k++) w_inflight = w_inflight + CNT_W'(r_tag_vld[k]);
  end

  assign w_issue_ok = (w_inflight + CNT_W'(w_fifo_count)) < CNT_W'(FIFO_DEPTH);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_grant_vld && i_req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      end
    end
  end

  assign w_grant_id  = ID_W'(w_grant_idx);
  assign w_accept    = w_grant_vld & w_issue_ok & rst_n;
  assign o_req_ready = w_accept ? (NUM_REQ'(1) << w_grant_idx) : '0;

  // Operand registers, round-robin pointer and the ID tag pipeline beside the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_mul_control <= 1'b0;
      r_rr_ptr      <= ID_W'(NUM_REQ - 1);
      r_tag_vld     <= '0;
      r_tag_id      <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[MUL_LAT-1:0], w_accept};
      r_tag_id  <= {r_tag_id[MUL_LAT-1:0], w_grant_id};
      if (w_accept) begin
        r_mul_a       <= i_req_a[OPND_W*w_grant_idx +: OPND_W];
        r_mul_b       <= i_req_b[OPND_W*w_grant_idx +: OPND_W];
        r_mul_control <= i_req_signed[w_grant_idx];
        r_rr_ptr      <= w_grant_id;
      end
    end
  end

  assign o_mul_a       = r_mul_a;
  assign o_mul_b       = r_mul_b;
  assign o_mul_control = r_mul_control;

  // The last tag stage lines up with the product currently on i_mul_p.
  assign w_wentry.id = r_tag_id[MUL_LAT];
  assign w_wentry.p  = i_mul_p;

  vmsu_rsp_fifo #(
    .DATA_W (ID_W + PROD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (r_tag_vld[MUL_LAT]),
    .i_wdata (w_wentry),
    .i_rd    (i_rsp_ready),
    .o_valid (o_rsp_valid),
    .o_rdata (w_head),
    .o_count (w_fifo_count)
  );

  assign o_rsp_id = w_head.id;
  assign o_rsp_p  = w_head.p;
  assign o_busy   = (w_inflight != '0) | (w_fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_vmsu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmsu_mul_arbiter
// Description : Directed self-checking bench for vmsu_mul_arbiter, with a
//               two-stage behavioural multiplier on the mul_* interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vmsu_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_signed = '0;
  logic [7:0]  mul_a, mul_b;
  logic        mul_control;
  logic [15:0] mul_p = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_p;
  logic        busy;

  logic [7:0]  m_a = '0, m_b = '0;
  logic        m_c = 1'b0;

  int          checks = 0;
  int          failures = 0;
  logic [17:0] q[$];
  logic [15:0] c_p [4] = '{16'd3, 16'd8, 16'd15, 16'd24};

  always #5 clk = ~clk;

  vmsu_mul_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_a       (req_a),
    .i_req_b       (req_b),
    .i_req_signed  (req_signed),
    .o_mul_a       (mul_a),
    .o_mul_b       (mul_b),
    .o_mul_control (mul_control),
    .i_mul_p       (mul_p),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_id      (rsp_id),
    .o_rsp_p       (rsp_p),
    .o_busy        (busy)
  );

  function automatic logic [15:0] mulf(logic [7:0] a, logic [7:0] b, logic s);
    logic signed [15:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (s) return 16'(sa * sb);
    return {8'b0, a} * {8'b0, b};
  endfunction

  // Behavioural multiplier: input flop then output flop.
  always @(posedge clk) begin
    m_a   <= mul_a;
    m_b   <= mul_b;
    m_c   <= mul_control;
    mul_p <= mulf(m_a, m_b, m_c);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Compare the head response with the oldest expected entry; retire it when popped.
  task automatic sb(string tag);
    if (rsp_valid) begin
      if (q.size() == 0) check({tag, "_extra"}, 32'(rsp_valid), 32'd0);
      else begin
        check({tag, "_id"}, 32'(rsp_id), 32'(q[0][17:16]));
        check({tag, "_p"},  32'(rsp_p),  32'(q[0][15:0]));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  endtask

  task automatic set_table();
    req_a      = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b      = {8'd6, 8'd5, 8'd4, 8'd3};
    req_signed = 4'b0000;
  endtask

  task automatic single(string tag, int idx, logic [7:0] a, logic [7:0] b, logic s, logic [15:0] exp);
    req_a[idx*8 +: 8] = a;
    req_b[idx*8 +: 8] = b;
    req_signed[idx]   = s;
    req_valid         = 4'b1 << idx;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(4'b1 << idx));
    step();
    req_valid = '0;
    check({tag, "_mul_a"}, 32'(mul_a), 32'(a));
    check({tag, "_mul_ctl"}, 32'(mul_control), 32'(s));
    step();
    step();
    check({tag, "_early"}, 32'(rsp_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(idx));
    check({tag, "_p"}, 32'(rsp_p), 32'(exp));
    step();
    check({tag, "_empty"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int grants, nxt, n;

    // Reset state
    #1 rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_rsp_p", 32'(rsp_p), 32'd0);
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;

    // Latency and products
    single("unsigned", 0, 8'd200, 8'd100, 1'b0, 16'h4E20);
    single("signed_a", 2, 8'hF6, 8'h05, 1'b1, 16'hFFCE);
    single("signed_b", 2, 8'h80, 8'h80, 1'b1, 16'h4000);

    // Fairness after a fresh reset: order 0,1,2,3,0,...
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    set_table();
    rsp_ready = 1'b1;
    grants = 0;
    nxt = 0;
    q.delete();
    for (int cyc = 0; cyc < 60 && (grants < 8 || q.size() != 0 || busy); cyc++) begin
      req_valid = (grants < 8) ? 4'hF : 4'h0;
      #1;
      if (req_ready != '0) begin
        check("fair_grant", 32'(req_ready), 32'(4'b1 << nxt));
        q.push_back({nxt[1:0], c_p[nxt]});
        nxt = (nxt + 1) % 4;
        grants++;
      end
      step();
      sb("fair");
    end
    req_valid = '0;
    check("fair_count", 32'(grants), 32'd8);
    check("fair_drain", 32'(q.size()), 32'd0);

    // Backpressure: exactly FIFO_DEPTH accepts with no consumer
    rsp_ready = 1'b0;
    grants = 0;
    nxt = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      req_valid = 4'hF;
      #1;
      if (req_ready != '0) begin
        check("bp_grant", 32'(req_ready), 32'(4'b1 << nxt));
        q.push_back({nxt[1:0], c_p[nxt]});
        nxt = (nxt + 1) % 4;
        grants++;
      end
      step();
      sb("bp");
    end
    check("bp_accepts", 32'(grants), 32'd4);
    check("bp_stall", 32'(req_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    req_a[7:0] = 8'h7F;
    req_b[7:0] = 8'h02;
    rsp_ready = 1'b1;
    #1;
    sb("bp_pop");
    step();
    rsp_ready = 1'b0;
    #1;
    check("bp_reissue", 32'(req_ready), 32'd1);
    q.push_back({2'd0, 16'h00FE});
    step();
    req_valid = '0;
    step();
    step();
    // Product of the re-issued op is now at the last tag stage; pop at the same edge
    rsp_ready = 1'b1;
    #1;
    sb("bp_pp");
    step();
    rsp_ready = 1'b0;
    check("bp_pp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 20 && rsp_valid; cyc++) begin
      n++;
      sb("bp_drain");
      step();
    end
    check("bp_drain_n", 32'(n), 32'd3);
    check("bp_drain_q", 32'(q.size()), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);

    // Reset with two in flight and two queued
    set_table();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    repeat (5) step();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_queued", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_mul_a", 32'(mul_a), 32'd0);
    check("mid_mul_b", 32'(mul_b), 32'd0);
    check("mid_mul_ctl", 32'(mul_control), 32'd0);
    check("mid_ready", 32'(req_ready), 32'd0);
    check("mid_rsp_id", 32'(rsp_id), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_first", 32'(req_ready), 32'd1);
    q.delete();
    q.push_back({2'd0, 16'd3});
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 20 && (busy || rsp_valid); cyc++) begin
      if (rsp_valid) n++;
      sb("mid");
      step();
    end
    check("mid_resp_n", 32'(n), 32'd1);
    check("mid_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
